// File: rtl/ssvep_lockin_mixer.sv
// Lock-in I/Q mixer for one ADS1299 channel: phase accumulator, quarter-wave sine ROM, 24x16 multiply.
// Optional quadrature path built only when LOCKIN_QUADRATURE_EN is defined (otherwise data_out_q is 0).
`timescale 1ns/1ps
module ssvep_lockin_mixer #(
  parameter int LUT_ADDR_BITS = 8,
  parameter int REF_WIDTH     = 16,
  parameter int WRAP_SAT      = 65535
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic               bypass,
  input  logic               phase_reset,
  input  logic               data_valid,
  input  logic signed [23:0] data,
  input  logic [31:0]        phase_inc_in,
  output logic signed [63:0] data_out_i,
  output logic signed [63:0] data_out_q,
  output logic               data_out_valid,
  output logic [15:0]        wrap_count,
  output logic               ready
);

  localparam int          DW            = 24;
  localparam int          PW            = DW + REF_WIDTH;
  localparam int          QTR           = (1 << LUT_ADDR_BITS) / 4;
  localparam int          IW            = LUT_ADDR_BITS - 1;
  localparam logic [31:0] PHASE_INC_RST = 32'h0147_AE14;
  localparam logic [15:0] L_WRAP_SAT    = 16'(WRAP_SAT);

  // First quadrant of round(32767*sin(2*pi*k/256)), k = 0..64; the rest is mirrored/negated.
  localparam logic [REF_WIDTH-1:0] QSIN [0:64] = '{
    16'd0,     16'd804,   16'd1608,  16'd2410,  16'd3212,  16'd4011,  16'd4808,  16'd5602,
    16'd6393,  16'd7179,  16'd7962,  16'd8739,  16'd9512,  16'd10278, 16'd11039, 16'd11793,
    16'd12539, 16'd13279, 16'd14010, 16'd14732, 16'd15446, 16'd16151, 16'd16846, 16'd17530,
    16'd18204, 16'd18868, 16'd19519, 16'd20159, 16'd20787, 16'd21403, 16'd22005, 16'd22594,
    16'd23170, 16'd23731, 16'd24279, 16'd24811, 16'd25329, 16'd25832, 16'd26319, 16'd26790,
    16'd27245, 16'd27683, 16'd28105, 16'd28510, 16'd28898, 16'd29268, 16'd29621, 16'd29956,
    16'd30273, 16'd30571, 16'd30852, 16'd31113, 16'd31356, 16'd31580, 16'd31785, 16'd31971,
    16'd32137, 16'd32285, 16'd32412, 16'd32521, 16'd32609, 16'd32678, 16'd32728, 16'd32757,
    16'd32767
  };

  function automatic logic signed [REF_WIDTH-1:0] f_lut(input logic [LUT_ADDR_BITS-1:0] addr);
    logic [IW-1:0]        idx;
    logic [REF_WIDTH-1:0] mag;
    if (addr[LUT_ADDR_BITS-2])
      idx = IW'(QTR) - IW'(addr[LUT_ADDR_BITS-3:0]);
    else
      idx = IW'(addr[LUT_ADDR_BITS-3:0]);
    mag = QSIN[idx];
    f_lut = addr[LUT_ADDR_BITS-1] ? -$signed(mag) : $signed(mag);
  endfunction

  logic [31:0] r_phase_inc;
  logic [31:0] r_acc;
  logic [15:0] r_wrap_count;

  logic                     w_accept;
  logic [31:0]              w_acc_base;
  logic [32:0]              w_acc_sum;
  logic [LUT_ADDR_BITS-1:0] w_addr;

  assign w_accept   = enable & data_valid;
  // A same-cycle phase_reset makes the current sample see phase 0.
  assign w_acc_base = phase_reset ? 32'd0 : r_acc;
  assign w_acc_sum  = {1'b0, w_acc_base} + {1'b0, r_phase_inc};
  assign w_addr     = w_acc_base[31 -: LUT_ADDR_BITS];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_phase_inc  <= PHASE_INC_RST;
      r_acc        <= '0;
      r_wrap_count <= '0;
    end else begin
      if (!enable)
        r_phase_inc <= phase_inc_in;
      if (w_accept) begin
        r_acc <= w_acc_sum[31:0];
        if (w_acc_sum[32] && (r_wrap_count != L_WRAP_SAT))
          r_wrap_count <= r_wrap_count + 16'd1;
      end else if (phase_reset) begin
        r_acc <= '0;
      end
    end
  end

  // S1: capture sample and table address
  logic                     r_s1_valid;
  logic                     r_s1_bypass;
  logic signed [DW-1:0]     r_s1_data;
  logic [LUT_ADDR_BITS-1:0] r_s1_addr;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_s1_valid  <= 1'b0;
      r_s1_bypass <= 1'b0;
      r_s1_data   <= '0;
      r_s1_addr   <= '0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_bypass <= bypass;
        r_s1_data   <= data;
        r_s1_addr   <= w_addr;
      end
    end
  end

  // S2: registered table read
  logic                        r_s2_valid;
  logic                        r_s2_bypass;
  logic signed [DW-1:0]        r_s2_data;
  logic signed [REF_WIDTH-1:0] r_s2_sin;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_s2_valid  <= 1'b0;
      r_s2_bypass <= 1'b0;
      r_s2_data   <= '0;
      r_s2_sin    <= '0;
    end else begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_bypass <= r_s1_bypass;
        r_s2_data   <= r_s1_data;
        r_s2_sin    <= f_lut(r_s1_addr);
      end
    end
  end

  // S3: multiplier register followed by the output register, which holds between strobes
  logic                 r_s3_valid;
  logic signed [PW-1:0] r_s3_i;
  logic                 r_out_valid;
  logic signed [63:0]   r_out_i;
  logic signed [PW-1:0] w_prod_i;
  logic signed [PW-1:0] w_data_ext;

  assign w_data_ext = PW'(r_s2_data);
  assign w_prod_i   = w_data_ext * PW'(r_s2_sin);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_s3_valid  <= 1'b0;
      r_s3_i      <= '0;
      r_out_valid <= 1'b0;
      r_out_i     <= '0;
    end else begin
      r_s3_valid  <= r_s2_valid;
      r_out_valid <= r_s3_valid;
      if (r_s2_valid)
        r_s3_i <= r_s2_bypass ? w_data_ext : w_prod_i;
      if (r_s3_valid)
        r_out_i <= 64'(r_s3_i);
    end
  end

`ifdef LOCKIN_QUADRATURE_EN
  logic signed [REF_WIDTH-1:0] r_s2_cos;
  logic signed [PW-1:0]        r_s3_q;
  logic signed [63:0]          r_out_q;
  logic signed [PW-1:0]        w_prod_q;
  logic [LUT_ADDR_BITS-1:0]    w_cos_addr;

  assign w_cos_addr = r_s1_addr + LUT_ADDR_BITS'(QTR);
  assign w_prod_q   = w_data_ext * PW'(r_s2_cos);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_s2_cos <= '0;
      r_s3_q   <= '0;
      r_out_q  <= '0;
    end else begin
      if (r_s1_valid)
        r_s2_cos <= f_lut(w_cos_addr);
      if (r_s2_valid)
        r_s3_q <= r_s2_bypass ? '0 : w_prod_q;
      if (r_s3_valid)
        r_out_q <= 64'(r_s3_q);
    end
  end

  assign data_out_q = r_out_q;
`else
  assign data_out_q = '0;
`endif

  assign data_out_i     = r_out_i;
  assign data_out_valid = r_out_valid;
  assign wrap_count     = r_wrap_count;
  assign ready          = reset;

endmodule

// File: doc/ssvep_lockin_mixer.md
# ssvep_lockin_mixer

Lock-in demodulation front end for one ADS1299 channel. Multiplies each incoming 24-bit signed sample by sine and cosine references taken from an internal 256-entry table, which is addressed by a phase accumulator that steps once per accepted sample. Emits 64-bit sign-extended in-phase (I) and quadrature (Q) products on an Avalon-ST-style valid interface. The block sits directly upstream of the per-channel IIR low-pass filters (one filter on I, one on Q), whose 64-bit `data`/`data_valid` inputs it drives.

## Interface
Parameters:
- `LUT_ADDR_BITS`, 8: sine table address width (table has 2^8 entries).
- `REF_WIDTH`, 16: signed reference width, Q1.15.
- `WRAP_SAT`, 65535: saturation value of `wrap_count`.

Ports:
- `clock`, in, 1: single clock.
- `reset`, in, 1: asynchronous, active-low.
- `enable`, in, 1: while high, samples are accepted; while low, `phase_inc_in` is loaded.
- `bypass`, in, 1: I output carries the raw sample instead of the mixed product.
- `phase_reset`, in, 1: synchronous clear of the phase accumulator.
- `data_valid`, in, 1: input sample strobe.
- `data`, in, 24 signed: ADS1299 channel sample.
- `phase_inc_in`, in, 32: phase increment per sample.
- `data_out_i`, out, 64 signed: in-phase product.
- `data_out_q`, out, 64 signed: quadrature product.
- `data_out_valid`, out, 1: one-cycle strobe per result.
- `wrap_count`, out, 16: number of reference periods completed (counts accumulator wraps).
- `ready`, out, 1: equals `reset`.

## Operation
- `phase_inc`: 32-bit register.
  - Loaded from `phase_inc_in` on every clock while `enable`=0.
  - Default after reset: 32'h0147_AE14.
- Phase accumulator `acc` (32 bits):
  - On each accepted sample (`enable`=1 and `data_valid`=1), the sample uses the current `acc`, then `acc <= acc + phase_inc` (mod 2^32).
  - Address is `acc[31:24]`.
  - sin = `LUT[addr]`.
  - cos = `LUT[addr + 64]` (mod 256).
- Table contents: `LUT[k] = round(32767·sin(2πk/256))`. Constant ROM.
- `phase_reset`=1:
  - Sets `acc` to 0.
  - If a sample is accepted in the same cycle, that sample uses phase 0 and `acc` becomes `phase_inc`.
- `wrap_count`:
  - Increments when the addition carries out of bit 31.
  - Saturates at `WRAP_SAT`.
  - Cleared only by reset.
- Arithmetic:
  - Product is `data` (24 bits) × ref (16 bits), giving 40 bits signed, sign-extended to 64.
  - No rounding or shift, so a full-scale product occupies at most 39 magnitude bits plus sign.
  - The downstream filter's 16-bit internal scaling therefore fits in 64 bits.
- `bypass`=1:
  - `data_out_i` = sign-extended `data`.
  - `data_out_q` = 0.
  - Same latency as normal mode; phase still advances.
- `data_valid` while `enable`=0: ignored. No output strobe; `acc` is held.

## Timing
- Pipeline, 3 stages; each stage carries a valid bit:
  - S1: register sample and table address.
  - S2: registered table read of sin and cos.
  - S3: registered multiply.
- Latency: accepted sample at edge N → `data_out_valid` high for exactly one cycle after edge N+3.
- Throughput: one sample per clock; back-to-back `data_valid` is supported.
- Outputs hold their last value between strobes.
- Deasserting `enable` mid-flight: samples already in the pipeline complete and strobe normally.
- Reset values:
  - `data_out_i`=0, `data_out_q`=0, `data_out_valid`=0, `wrap_count`=0.
  - `acc`=0, all pipeline valid bits 0.
- Reset mid-operation: in-flight samples are discarded and no strobe follows.

## Configuration
- `LOCKIN_QUADRATURE_EN`:
  - Defined: Q path (cos read + second multiplier) is built as described.
  - Undefined: cos read and Q multiplier are removed and `data_out_q` is constant 0. I path, latency and strobe timing are unchanged.

## Test plan
- Quadrature mixing:
  - Stimulus: `phase_inc`=2^30 loaded with `enable`=0, then `enable`=1 and 8 back-to-back samples of `data`=1000.
  - I results: 0, 32767000, 0, −32767000, repeating.
  - Q results: 32767000, 0, −32767000, 0, repeating.
  - `wrap_count`=2 after the 8 samples.
  - Each result appears 3 cycles after its sample.
- Sign and range:
  - Stimulus: `data`=−8388608 (−2^23) at phase 64, where sin = +32767.
  - Required: `data_out_i` = −274869518336, correctly sign-extended to 64 bits.
- Phase reset with a simultaneous sample:
  - Stimulus: `phase_reset` asserted in the same cycle as a sample, with `acc` mid-cycle.
  - Required: that sample's I result is 0, and the next sample uses address `phase_inc[31:24]`.
- Bypass and gating:
  - Stimulus: `bypass`=1 with `data`=−5.
  - Required: `data_out_i`=−5 and `data_out_q`=0 after 3 cycles.
  - Stimulus: `data_valid` pulses while `enable`=0.
  - Required: no strobe, and `acc` unchanged.
- Reset mid-pipeline:
  - Stimulus: assert `reset`=0 one cycle after accepting a sample.
  - Required: all outputs are 0 immediately (asynchronously), and no strobe follows release.
- Macro off:
  - Stimulus: build without `LOCKIN_QUADRATURE_EN` and repeat the quadrature mixing scenario.
  - Required: identical I sequence, and `data_out_q` stays 0.
